// File: rtl/regfile_pkg.sv
// Shared defaults and types for the parametrised register file with RAW scoreboard.
package regfile_pkg;

  localparam int W_DEF    = 19;
  localparam int NREG_DEF = 32;
  localparam int NRD_DEF  = 2;
  localparam int CW_DEF   = 2;

  typedef logic [W_DEF-1:0]             reg_data_t;
  typedef logic [$clog2(NREG_DEF)-1:0]  reg_addr_t;

  // Largest number of writes a CW-bit pending counter can track.
  function automatic int cnt_max(input int cw);
    return (1 << cw) - 1;
  endfunction

endpackage

// File: rtl/regfile_sb_cnt.sv
// Per-register pending-write counter: saturating up/down, simultaneous inc+dec cancel.
module regfile_sb_cnt
  import regfile_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          dec,
  output logic [CW-1:0] cnt,
  output logic          full,
  output logic          nonzero
);

  logic dn_req;
  logic up;
  logic dn;

  assign full    = &cnt;
  assign nonzero = |cnt;

  // A decrement on an empty counter is meaningless, so it cannot cancel an increment.
  assign dn_req = dec && nonzero;
  assign up     = inc && !dn_req && !full;
  assign dn     = dn_req && !inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (up) begin
      cnt <= cnt + CW'(1);
    end else if (dn) begin
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// Register file with write-first bypass and per-register pending-write scoreboard.
// Optional: define REGFILE_R0_ZERO_EN to hardwire register 0 to zero.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter  int W    = W_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int NRD  = NRD_DEF,
  parameter  int CW   = CW_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NRD*AW-1:0] ra,
  output logic [NRD*W-1:0]  rd,
  output logic [NRD-1:0]    rd_pend,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_addr,
  output logic            iss_ready,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [W-1:0]    wd,
  output logic            idle
);

`ifdef REGFILE_R0_ZERO_EN
  localparam bit R0_ZERO = 1'b1;
`else
  localparam bit R0_ZERO = 1'b0;
`endif

  logic [W-1:0]  mem [NREG];
  logic [CW-1:0] cnt [NREG];
  logic [NREG-1:0] full;
  logic [NREG-1:0] nonzero;
  logic [NREG-1:0] inc;
  logic [NREG-1:0] dec;
  logic wr_en;
  logic iss_fire;

  // Gating with reset keeps the bypass from leaking wd while the file is held clear.
  assign wr_en    = we && reset && !(R0_ZERO && (wa == '0));
  assign iss_fire = iss_valid && iss_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < NREG; r++) begin
        mem[r] <= '0;
      end
    end else if (wr_en) begin
      mem[wa] <= wd;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_cnt
    assign inc[g] = iss_fire && (iss_addr == AW'(g)) && !(R0_ZERO && (g == 0));
    assign dec[g] = wr_en && (wa == AW'(g)) && nonzero[g];

    regfile_sb_cnt #(.CW(CW)) u_cnt (
      .clk     (clk),
      .reset   (reset),
      .inc     (inc[g]),
      .dec     (dec[g]),
      .cnt     (cnt[g]),
      .full    (full[g]),
      .nonzero (nonzero[g])
    );
  end

  // A full counter can still accept an issue when a write retires one slot this cycle.
  assign iss_ready = !full[iss_addr]
                   || (wr_en && (wa == iss_addr) && nonzero[iss_addr])
                   || (R0_ZERO && (iss_addr == '0));

  assign idle = ~|nonzero;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0] a;
    logic          byp;

    assign a   = ra[i*AW +: AW];
    assign byp = wr_en && (wa == a);

    assign rd[i*W +: W] = byp ? wd : mem[a];
    // One outstanding write landing now is satisfied by the bypass.
    assign rd_pend[i]   = (cnt[a] > CW'(1)) || ((cnt[a] == CW'(1)) && !byp);
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard-driven bench for regfile_scoreboard; honours REGFILE_R0_ZERO_EN.
module tb_regfile_scoreboard;

  localparam int W  = 19;
  localparam int AW = 5;
  localparam int OW = 2*W + 2 + 2;

  logic          clk;
  logic          reset;
  logic [2*AW-1:0] ra;
  logic [2*W-1:0]  rd;
  logic [1:0]    rd_pend;
  logic          iss_valid;
  logic [AW-1:0] iss_addr;
  logic          iss_ready;
  logic          we;
  logic [AW-1:0] wa;
  logic [W-1:0]  wd;
  logic          idle;

  logic [OW-1:0] obs;
  logic [OW-1:0] e;
  logic [OW-1:0] exp_q[$];
  int vectors;
  int miscompares;

  regfile_scoreboard dut (
    .clk       (clk),
    .reset     (reset),
    .ra        (ra),
    .rd        (rd),
    .rd_pend   (rd_pend),
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .iss_ready (iss_ready),
    .we        (we),
    .wa        (wa),
    .wd        (wd),
    .idle      (idle)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign obs = {rd, rd_pend, idle, iss_ready};

  function automatic logic [OW-1:0] pk(input logic [W-1:0] rd1, input logic [W-1:0] rd0,
                                       input logic [1:0] pend, input logic idl, input logic rdy);
    return {rd1, rd0, pend, idl, rdy};
  endfunction

  // Inputs change on the falling edge so they are stable well before the next rising edge.
  task automatic set_in(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic v,
                        input logic [AW-1:0] ia, input logic w, input logic [AW-1:0] a,
                        input logic [W-1:0] d);
    @(negedge clk);
    ra        = {a1, a0};
    iss_valid = v;
    iss_addr  = ia;
    we        = w;
    wa        = a;
    wd        = d;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    @(negedge clk);
    exp_q.push_back(pk('0, '0, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL reset_held: actual %h required %h", obs, e); end
    set_in(5'd1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    reset = 1'b1;
    exp_q.push_back(pk('0, '0, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL reset_released: actual %h required %h", obs, e); end
  endtask

  task automatic test_write_bypass;
    set_in(5'd2, 5'd5, 1'b0, 5'd0, 1'b1, 5'd2, 19'h4);
    exp_q.push_back(pk('0, 19'h4, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL bypass_same_cycle: actual %h required %h", obs, e); end
    set_in(5'd2, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    exp_q.push_back(pk('0, 19'h4, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL write_stored: actual %h required %h", obs, e); end
  endtask

  task automatic test_raw;
    set_in(5'd3, 5'd2, 1'b1, 5'd3, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(19'h4, '0, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL raw_issue: actual %h required %h", obs, e); end
    set_in(5'd3, 5'd2, 1'b0, 5'd3, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(19'h4, '0, 2'b01, 1'b0, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL raw_pending: actual %h required %h", obs, e); end
    set_in(5'd3, 5'd2, 1'b0, 5'd3, 1'b1, 5'd3, 19'h7FFFF);
    exp_q.push_back(pk(19'h4, 19'h7FFFF, 2'b00, 1'b0, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL raw_writeback: actual %h required %h", obs, e); end
    set_in(5'd3, 5'd2, 1'b0, 5'd3, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(19'h4, 19'h7FFFF, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL raw_idle: actual %h required %h", obs, e); end
  endtask

  task automatic test_saturation;
    logic [OW-1:0] issue_exp [4];
    issue_exp[0] = pk('0, '0, 2'b00, 1'b1, 1'b1);
    issue_exp[1] = pk('0, '0, 2'b01, 1'b0, 1'b1);
    issue_exp[2] = pk('0, '0, 2'b01, 1'b0, 1'b1);
    issue_exp[3] = pk('0, '0, 2'b01, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      set_in(5'd4, 5'd5, 1'b1, 5'd4, 1'b0, 5'd0, '0);
      exp_q.push_back(issue_exp[k]);
      #1;
      e = exp_q.pop_front(); vectors++;
      if (obs !== e) begin miscompares++; $display("[TB] FAIL sat_issue%0d: actual %h required %h", k, obs, e); end
    end
    set_in(5'd4, 5'd5, 1'b0, 5'd5, 1'b0, 5'd0, '0);
    exp_q.push_back(pk('0, '0, 2'b01, 1'b0, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL sat_other_ready: actual %h required %h", obs, e); end
    set_in(5'd4, 5'd5, 1'b0, 5'd4, 1'b0, 5'd0, '0);
    exp_q.push_back(pk('0, '0, 2'b01, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL sat_held_full: actual %h required %h", obs, e); end
    set_in(5'd4, 5'd5, 1'b1, 5'd4, 1'b1, 5'd4, 19'h123);
    exp_q.push_back(pk('0, 19'h123, 2'b01, 1'b0, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL sat_issue_with_write: actual %h required %h", obs, e); end
    set_in(5'd4, 5'd5, 1'b0, 5'd4, 1'b0, 5'd0, '0);
    exp_q.push_back(pk('0, 19'h123, 2'b01, 1'b0, 1'b0));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL sat_count_kept: actual %h required %h", obs, e); end
    for (int k = 0; k < 3; k++) begin
      set_in(5'd4, 5'd5, 1'b0, 5'd4, 1'b1, 5'd4, 19'h123);
    end
    set_in(5'd4, 5'd5, 1'b0, 5'd4, 1'b0, 5'd0, '0);
    exp_q.push_back(pk('0, 19'h123, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL sat_drained: actual %h required %h", obs, e); end
  endtask

  task automatic test_edge;
    set_in(5'd6, 5'd3, 1'b0, 5'd6, 1'b1, 5'd6, 19'h2A);
    exp_q.push_back(pk(19'h7FFFF, 19'h2A, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL untracked_write: actual %h required %h", obs, e); end
    set_in(5'd6, 5'd3, 1'b0, 5'd6, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(19'h7FFFF, 19'h2A, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL no_underflow: actual %h required %h", obs, e); end
    set_in(5'd3, 5'd6, 1'b1, 5'd3, 1'b0, 5'd0, '0);
    set_in(5'd3, 5'd6, 1'b1, 5'd3, 1'b0, 5'd0, '0);
    set_in(5'd3, 5'd6, 1'b0, 5'd3, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(19'h2A, 19'h7FFFF, 2'b01, 1'b0, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL two_pending: actual %h required %h", obs, e); end
    reset = 1'b0;
    exp_q.push_back(pk('0, '0, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL async_reset: actual %h required %h", obs, e); end
    set_in(5'd3, 5'd6, 1'b0, 5'd3, 1'b0, 5'd0, '0);
    reset = 1'b1;
    exp_q.push_back(pk('0, '0, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL after_async_reset: actual %h required %h", obs, e); end
  endtask

  task automatic test_r0;
`ifdef REGFILE_R0_ZERO_EN
    logic [W-1:0] r0v = '0;
    logic [1:0]   pend0 = 2'b00;
    logic         idle0 = 1'b1;
`else
    logic [W-1:0] r0v = 19'h55;
    logic [1:0]   pend0 = 2'b11;
    logic         idle0 = 1'b0;
`endif
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd0, 19'h55);
    exp_q.push_back(pk(r0v, r0v, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL r0_write_bypass: actual %h required %h", obs, e); end
    set_in(5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(r0v, r0v, 2'b00, 1'b1, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL r0_readback_issue: actual %h required %h", obs, e); end
    set_in(5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, '0);
    exp_q.push_back(pk(r0v, r0v, pend0, idle0, 1'b1));
    #1;
    e = exp_q.pop_front(); vectors++;
    if (obs !== e) begin miscompares++; $display("[TB] FAIL r0_after_issue: actual %h required %h", obs, e); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    ra          = '0;
    iss_valid   = 1'b0;
    iss_addr    = '0;
    we          = 1'b0;
    wa          = '0;
    wd          = '0;
    test_reset;
    test_write_bypass;
    test_raw;
    test_saturation;
    test_edge;
    test_r0;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: actual %0d required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Parametrised successor to the processor's 2-read/1-write register file.
- Generalises data width, register count and read-port count.
- Adds write-to-read bypass and a per-register pending-write scoreboard, so the decode stage can detect RAW hazards and stall.
- Sits between decode (read and issue) and writeback (write).

Parameters:
- W, 19, data width of each register.
- NREG, 32, number of registers (power of 2, >= 2).
- AW, $clog2(NREG), register address width (derived, not overridden).
- NRD, 2, number of read ports (1..4).
- CW, 2, width of each per-register pending counter (max in-flight writes = 2^CW-1).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ra  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rd  out  NRD*W  read data; port i uses bits [i*W +: W].
- rd_pend  out  NRD  port i's register has an outstanding write not satisfied this cycle.
- iss_valid  in  1  decode issues an instruction that will write iss_addr.
- iss_addr  in  AW  destination of the issued instruction.
- iss_ready  out  1  scoreboard can accept the issue.
- we  in  1  writeback enable (RegWriteW).
- wa  in  AW  writeback address.
- wd  in  W  writeback data (ResultW).
- idle  out  1  no pending writes anywhere.

Behaviour:
- Reset (reset=0, async):
  - All registers clear to 0.
  - All pending counters clear to 0.
  - iss_ready=1, idle=1.
  - rd returns 0 for every address.
  - rd_pend=0.
  - Reset asserted mid-operation discards all in-flight issues; no write is completed.
- Write:
  - When we=1, mem[wa] <= wd at the rising edge.
  - Writes with we=1 and a zero counter are legal (untracked writes).
- Read (combinational, 0-cycle latency):
  - rd[i] = wd when we=1 and wa==ra[i] (write-first bypass).
  - Otherwise rd[i] = mem[ra[i]].
- Scoreboard (per-register counter cnt[r], CW bits):
  - Issue handshake fires when iss_valid && iss_ready.
  - iss_ready = (cnt[iss_addr] != 2^CW-1) || (we && wa==iss_addr && cnt[wa]!=0).
  - Issue only: cnt[iss_addr] +1.
  - Write only (we=1, cnt[wa]!=0): cnt[wa] -1.
  - Issue and write to the same register in the same cycle: count unchanged.
  - Issue and write to different registers in the same cycle: both updates apply.
  - Write with cnt[wa]==0: count stays 0, no underflow.
  - iss_valid while iss_ready=0: no count change; decode must hold its request.
- rd_pend[i] = (cnt[ra[i]] > 1) || (cnt[ra[i]]==1 && !(we && wa==ra[i])).
  - A single outstanding write landing this cycle is satisfied by the bypass.
- idle = all cnt == 0, registered view of the current counts.
- No internal FSM beyond the counters; all state updates on the rising clk edge.

Optional Feature:
- Macro: REGFILE_R0_ZERO_EN.
- Defined:
  - Register 0 is hardwired to 0 and reads 0, including through the bypass.
  - Writes to address 0 are dropped.
  - Issues to address 0 always handshake but never increment cnt[0].
  - rd_pend is 0 for any port reading address 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Package regfile_pkg holds:
  - default constants W_DEF=19, NREG_DEF=32, NRD_DEF=2, CW_DEF=2;
  - typedef reg_data_t (logic [W_DEF-1:0]);
  - typedef reg_addr_t (logic [$clog2(NREG_DEF)-1:0]).
- One sub-module, regfile_sb_cnt: a single CW-bit saturating up/down counter with inc, dec, full and nonzero outputs, instantiated NREG times via generate.
- Storage, bypass mux and the rd_pend logic stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then read ra=1,2 -> rd=0, rd_pend=0, idle=1, iss_ready=1.
- Write and bypass: we=1, wa=2, wd=19'h4, ra0=2 in the same cycle -> rd0=19'h4 combinationally; next cycle we=0, ra0=2 -> rd0=19'h4, ra1=5 -> rd1=0.
- Scoreboard RAW:
  - Issue to reg 3 -> next cycle ra0=3 gives rd_pend[0]=1, idle=0.
  - Writeback wa=3, wd=19'h7FFFF that cycle -> rd_pend[0]=0, rd0=19'h7FFFF.
  - Following cycle -> idle=1.
- Saturation: with CW=2, issue to reg 4 three times -> iss_ready=0 for addr 4, a fourth issue is ignored; iss_ready stays 1 for addr 5.
  - Then issue(4) together with we wa=4 -> handshake accepted, count stays 3.
- Simultaneous and edge cases:
  - Write to reg 6 with cnt=0 -> count stays 0, data written.
  - Assert reset with cnt[3]=2 -> counts 0 and reg 3 reads 0 immediately (async).
- REGFILE_R0_ZERO_EN: write wa=0, wd=19'h55 -> rd for ra=0 is 0 in the same and next cycle; issue(0) -> iss_ready=1, idle stays 1.
  - Without the macro, the same write reads back 19'h55.
